// File: rtl/banked_regfile.sv
// rtl/banked_regfile.sv - banked ARM physical register file, 3 read / 2 write ports, init sweep
module banked_regfile #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 31
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [ADDR_W-1:0] rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic [ADDR_W-1:0] rc_addr_i,
  output logic [DATA_W-1:0] rc_data_o,
  input  logic              wa_en_i,
  input  logic [ADDR_W-1:0] wa_addr_i,
  input  logic [DATA_W-1:0] wa_data_i,
  input  logic              wb_en_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic              rf_ready_o
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rf_ready_q, rf_ready_d;
  logic [DATA_W-1:0] mem_q [NUM_REGS];

  logic              run;
  logic              wa_hit_any;
  logic              wb_live;
  logic [ADDR_W-1:0] rd_addr [3];
  logic [DATA_W-1:0] rd_data [3];

  assign run = (state_q == ST_RUN);

  // Port B is dropped when port A targets the same register in the same cycle
  assign wa_hit_any = wa_en_i && (wa_addr_i <= LAST_ADDR);
  assign wb_live    = wb_en_i && (wb_addr_i <= LAST_ADDR) &&
                      !(wa_en_i && (wa_addr_i == wb_addr_i));

  // State, sweep pointer and ready flag registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      rf_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rf_ready_q <= rf_ready_d;
    end
  end

  // Sweep sequencing: walk ptr through every register, then switch to RUN
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    rf_ready_d = rf_ready_q;
    case (state_q)
      ST_INIT: begin
        if (ptr_q == LAST_ADDR) begin
          state_d    = ST_RUN;
          rf_ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      ST_RUN: begin
        rf_ready_d = 1'b1;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Register array: zeroed by the sweep in INIT, written by ports A/B in RUN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (!run) begin
          if (ptr_q == ADDR_W'(i)) mem_q[i] <= '0;
        end else if (wa_hit_any && (wa_addr_i == ADDR_W'(i))) begin
          mem_q[i] <= wa_data_i;
        end else if (wb_live && (wb_addr_i == ADDR_W'(i))) begin
          mem_q[i] <= wb_data_i;
        end
      end
    end
  end

  assign rd_addr[0] = ra_addr_i;
  assign rd_addr[1] = rb_addr_i;
  assign rd_addr[2] = rc_addr_i;

  // Combinational reads with write-through bypass; A has priority over B
  always_comb begin
    for (int p = 0; p < 3; p++) begin
      rd_data[p] = '0;
      if (run && (rd_addr[p] <= LAST_ADDR)) begin
        if (wa_en_i && (wa_addr_i == rd_addr[p])) begin
          rd_data[p] = wa_data_i;
        end else if (wb_en_i && (wb_addr_i == rd_addr[p])) begin
          rd_data[p] = wb_data_i;
        end else begin
          rd_data[p] = mem_q[rd_addr[p]];
        end
      end
    end
  end

  assign ra_data_o  = rd_data[0];
  assign rb_data_o  = rd_data[1];
  assign rc_data_o  = rd_data[2];
  assign rf_ready_o = rf_ready_q;

endmodule
